// File: rtl/snn_pkg.sv
// snn_pkg: shared types and saturation helpers for the membrane integrator.
// Holds the FSM state enum, the membrane word typedef and the min/max
// helpers that the saturating arithmetic is built on.
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_INTEGRATE = 2'd1,
    ST_UPDATE    = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  localparam int MEMBRANE_WIDTH = 16;

  typedef logic signed [MEMBRANE_WIDTH-1:0] membrane_t;

  // Largest representable two's-complement value of the given width.
  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Smallest representable two's-complement value of the given width.
  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/membrane_integrator_if.sv
// membrane_integrator_if: input-beat bus carrying weighted partial sums
// into the membrane integrator.
//
// Handshake: a beat transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready depends only on the receiver's state,
// never on in_valid. While in_valid is high and the beat is not yet taken,
// the master holds in_current and in_last stable. in_last marks the final
// beat of a timestep.
interface membrane_integrator_if #(
  parameter int DATA_WIDTH = 16
);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_current;
  logic                         in_last;

  modport master (
    output in_valid,
    output in_current,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_current,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/sat_add.sv
// sat_add: DATA_WIDTH signed adder that clamps to the representable range
// instead of wrapping. The sum is formed one bit wider and the two top bits
// reveal overflow direction.
module sat_add
  import snn_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] y
);

  localparam logic signed [DATA_WIDTH-1:0] MAX_V = DATA_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic signed [DATA_WIDTH-1:0] MIN_V = DATA_WIDTH'(sat_min(DATA_WIDTH));

  logic signed [DATA_WIDTH:0] sum;

  // Widened add, then clamp when the top two bits disagree.
  always_comb begin
    sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
      y = sum[DATA_WIDTH] ? MIN_V : MAX_V;
    end else begin
      y = sum[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/membrane_integrator.sv
// membrane_integrator: leaky/non-leaky integrate-and-fire membrane stage.
// Accumulates input beats per timestep, then in a one-cycle UPDATE folds the
// accumulated current into the membrane potential, publishes it, and applies
// reset-by-subtraction when the threshold is reached.
// Optional build macro: MEMBRANE_LEAK_EN enables the leak term V >>> LEAK_SHIFT;
// without it the neuron is a pure integrate-and-fire.
module membrane_integrator
  import snn_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_TIMESTEPS = 8,
  parameter int LEAK_SHIFT    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  membrane_integrator_if.slave               in_bus,
  input  logic signed [DATA_WIDTH-1:0]       threshold,
  output logic signed [DATA_WIDTH-1:0]       membrane_potential,
  output logic                               potential_valid,
  output logic                               reset_accumulated_spikes,
  output logic [$clog2(NUM_TIMESTEPS)-1:0]   timestep,
  output logic                               busy,
  output logic                               done,
  output state_e                             state_dbg
);

  localparam int TS_W = $clog2(NUM_TIMESTEPS);
  localparam logic [TS_W-1:0] TS_LAST = TS_W'(NUM_TIMESTEPS - 1);
  localparam logic signed [DATA_WIDTH-1:0] MAX_V = DATA_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic signed [DATA_WIDTH-1:0] MIN_V = DATA_WIDTH'(sat_min(DATA_WIDTH));

  // Reject parameter sets the datapath cannot represent.
  if (NUM_TIMESTEPS < 2 || LEAK_SHIFT < 0 || LEAK_SHIFT >= DATA_WIDTH) begin : g_cfg_check
    $error("membrane_integrator: unsupported parameter set");
  end

  state_e                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] v_q, v_d;
  logic [TS_W-1:0]              ts_q, ts_d;
  logic signed [DATA_WIDTH-1:0] mp_q, mp_d;
  logic                         pv_q, pv_d;
  logic                         rsp_q, rsp_d;

  logic                         xfer;
  logic signed [DATA_WIDTH-1:0] acc_sum;
  logic signed [DATA_WIDTH-1:0] leak;
  logic signed [DATA_WIDTH-1:0] v_after_leak;
  logic signed [DATA_WIDTH-1:0] v_new;
  logic signed [DATA_WIDTH:0]   fire_diff;
  logic signed [DATA_WIDTH-1:0] v_fired;
  logic                         fire;

  assign in_bus.in_ready = (state_q == ST_INTEGRATE);
  assign xfer            = in_bus.in_valid && in_bus.in_ready;

  // Running sum of this timestep's beats.
  sat_add #(.DATA_WIDTH(DATA_WIDTH)) u_acc_add (
    .a (acc_q),
    .b (in_bus.in_current),
    .y (acc_sum)
  );

  // New potential: leaked V plus the completed timestep's current.
  sat_add #(.DATA_WIDTH(DATA_WIDTH)) u_v_add (
    .a (v_after_leak),
    .b (acc_q),
    .y (v_new)
  );

  // Leak term; V - (V >>> k) keeps V's sign and shrinks it, so it cannot overflow.
  always_comb begin
`ifdef MEMBRANE_LEAK_EN
    leak = v_q >>> LEAK_SHIFT;
`else
    leak = '0;
`endif
    v_after_leak = v_q - leak;
  end

  // Firing decision and reset-by-subtraction, clamped for negative thresholds.
  always_comb begin
    fire      = (v_new >= threshold);
    fire_diff = {v_new[DATA_WIDTH-1], v_new} - {threshold[DATA_WIDTH-1], threshold};
    if (fire_diff[DATA_WIDTH] != fire_diff[DATA_WIDTH-1]) begin
      v_fired = fire_diff[DATA_WIDTH] ? MIN_V : MAX_V;
    end else begin
      v_fired = fire_diff[DATA_WIDTH-1:0];
    end
  end

  // Next-state and datapath updates for the window sequencer.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    v_d     = v_q;
    ts_d    = ts_q;
    mp_d    = mp_q;
    pv_d    = 1'b0;
    rsp_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = '0;
          v_d     = '0;
          ts_d    = '0;
          rsp_d   = 1'b1;
          state_d = ST_INTEGRATE;
        end
      end
      ST_INTEGRATE: begin
        if (xfer) begin
          acc_d = acc_sum;
          if (in_bus.in_last) begin
            state_d = ST_UPDATE;
          end
        end
      end
      ST_UPDATE: begin
        mp_d  = v_new;
        pv_d  = 1'b1;
        acc_d = '0;
        v_d   = fire ? v_fired : v_new;
        if (ts_q == TS_LAST) begin
          state_d = ST_DONE;
        end else begin
          ts_d    = ts_q + TS_W'(1);
          state_d = ST_INTEGRATE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any window in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      v_q     <= '0;
      ts_q    <= '0;
      mp_q    <= '0;
      pv_q    <= 1'b0;
      rsp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      v_q     <= v_d;
      ts_q    <= ts_d;
      mp_q    <= mp_d;
      pv_q    <= pv_d;
      rsp_q   <= rsp_d;
    end
  end

  assign membrane_potential       = mp_q;
  assign potential_valid          = pv_q;
  assign reset_accumulated_spikes = rsp_q;
  assign timestep                 = ts_q;
  assign busy                     = (state_q != ST_IDLE);
  assign done                     = (state_q == ST_DONE);
  assign state_dbg                = state_q;

endmodule

// File: tb/tb_membrane_integrator.sv
// tb_membrane_integrator: randomized and directed bench for membrane_integrator
// with DATA_WIDTH=16, NUM_TIMESTEPS=4, LEAK_SHIFT=2. Expected potentials come
// from a window-level arithmetic model of the neuron rules.
module tb_membrane_integrator;
  import snn_pkg::*;

  localparam int DW = 16;
  localparam int NT = 4;
  localparam int LS = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic signed [DW-1:0] threshold = 16'sd1000;
  logic signed [DW-1:0] membrane_potential;
  logic                 potential_valid;
  logic                 reset_accumulated_spikes;
  logic [1:0]           timestep;
  logic                 busy;
  logic                 done;
  state_e               state_dbg;

  membrane_integrator_if #(.DATA_WIDTH(DW)) bus ();

  membrane_integrator #(
    .DATA_WIDTH    (DW),
    .NUM_TIMESTEPS (NT),
    .LEAK_SHIFT    (LS)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .start                    (start),
    .in_bus                   (bus),
    .threshold                (threshold),
    .membrane_potential       (membrane_potential),
    .potential_valid          (potential_valid),
    .reset_accumulated_spikes (reset_accumulated_spikes),
    .timestep                 (timestep),
    .busy                     (busy),
    .done                     (done),
    .state_dbg                (state_dbg)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0]        exp_q[$];
  logic signed [DW-1:0] obs_pot_q[$];
  int                   pv_cyc_q[$];
  int                   last_cyc_q[$];
  int                   rsp_cnt = 0;
  int                   done_cnt = 0;
  int                   pb, lb, rb, db;
  int                   win_cur[$];
  bit                   win_last[$];

  // Record every observable event away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (potential_valid) begin
        obs_pot_q.push_back(membrane_potential);
        pv_cyc_q.push_back(cyc);
      end
      if (reset_accumulated_spikes) rsp_cnt++;
      if (done) done_cnt++;
      if (bus.in_valid && bus.in_ready && bus.in_last) last_cyc_q.push_back(cyc);
    end
  end

  // ---------------- reference model ----------------
  function automatic int clamp16(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic int leak_of(input int v);
`ifdef MEMBRANE_LEAK_EN
    if (v >= 0) return v / (1 << LS);
    return -((-v + (1 << LS) - 1) / (1 << LS));
`else
    return 0 * v;
`endif
  endfunction

  task automatic model_window(input int thr);
    int v, acc, vn, i;
    bit last;
    exp_q.delete();
    v = 0;
    i = 0;
    for (int ts = 0; ts < NT; ts++) begin
      acc = 0;
      do begin
        acc  = clamp16(acc + win_cur[i]);
        last = win_last[i];
        i++;
      end while (!last && i < win_cur.size());
      vn = clamp16(v - leak_of(v) + acc);
      exp_q.push_back(16'(vn));
      v = (vn >= thr) ? clamp16(vn - thr) : vn;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic snap();
    pb = obs_pot_q.size();
    lb = last_cyc_q.size();
    rb = rsp_cnt;
    db = done_cnt;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input int cur, input bit last);
    bit ok;
    int waited;
    ok = 1'b0;
    waited = 0;
    bus.in_valid   = 1'b1;
    bus.in_current = 16'(cur);
    bus.in_last    = last;
    while (!ok && waited < 64) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      waited++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_accept got in_ready=0 want 1 within 64 cycles");
    end
  endtask

  task automatic idle_cycles(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_window(input int gap_max);
    for (int i = 0; i < win_cur.size(); i++) begin
      idle_cycles($urandom_range(0, gap_max));
      send_beat(win_cur[i], win_last[i]);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 300);
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout got busy=1 want 0 within 300 cycles", tag);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++; if (membrane_potential !== 16'sd0) begin errors++; $display("FAIL reset_mp got %0d want 0", membrane_potential); end
    checks++; if (potential_valid !== 1'b0) begin errors++; $display("FAIL reset_pv got %b want 0", potential_valid); end
    checks++; if (reset_accumulated_spikes !== 1'b0) begin errors++; $display("FAIL reset_rsp got %b want 0", reset_accumulated_spikes); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (timestep !== 2'd0) begin errors++; $display("FAIL reset_timestep got %0d want 0", timestep); end
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want 0", state_dbg); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_integrate();
    threshold = 16'sd1000;
    win_cur.delete();
    win_last.delete();
    for (int t = 0; t < NT; t++) begin
      win_cur.push_back(100);
      win_last.push_back(1'b1);
    end
    exp_q.delete();
`ifdef MEMBRANE_LEAK_EN
    exp_q.push_back(16'd100); exp_q.push_back(16'd175); exp_q.push_back(16'd232); exp_q.push_back(16'd274);
`else
    exp_q.push_back(16'd100); exp_q.push_back(16'd200); exp_q.push_back(16'd300); exp_q.push_back(16'd400);
`endif
    snap();
    start_pulse();
    drive_window(0);
    wait_idle("integrate");
    checks++;
    if (obs_pot_q.size() - pb !== exp_q.size()) begin
      errors++; $display("FAIL integrate_pv_count got %0d want %0d", obs_pot_q.size() - pb, exp_q.size());
    end
    foreach (exp_q[i]) if (pb + i < obs_pot_q.size()) begin
      checks++;
      if (obs_pot_q[pb + i] !== exp_q[i]) begin
        errors++; $display("FAIL integrate_mp[%0d] got %0d want %0d", i, obs_pot_q[pb + i], $signed(exp_q[i]));
      end
    end
    for (int i = 0; i < NT; i++) if (pb + i < pv_cyc_q.size() && lb + i < last_cyc_q.size()) begin
      checks++;
      if (pv_cyc_q[pb + i] - last_cyc_q[lb + i] != 2) begin
        errors++; $display("FAIL integrate_latency[%0d] got %0d want 2", i, pv_cyc_q[pb + i] - last_cyc_q[lb + i]);
      end
    end
    checks++; if (rsp_cnt - rb != 1) begin errors++; $display("FAIL integrate_rsp_pulses got %0d want 1", rsp_cnt - rb); end
    checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL integrate_done_pulses got %0d want 1", done_cnt - db); end
    checks++; if (membrane_potential !== 16'(exp_q[NT-1])) begin
      errors++; $display("FAIL integrate_mp_hold got %0d want %0d", membrane_potential, $signed(exp_q[NT-1]));
    end
  endtask

  task automatic test_threshold();
    threshold = 16'sd150;
    win_cur.delete();
    win_last.delete();
    for (int t = 0; t < NT; t++) begin
      win_cur.push_back(100);
      win_last.push_back(1'b1);
    end
    exp_q.delete();
`ifdef MEMBRANE_LEAK_EN
    exp_q.push_back(16'd100); exp_q.push_back(16'd175); exp_q.push_back(16'd119); exp_q.push_back(16'd190);
`else
    exp_q.push_back(16'd100); exp_q.push_back(16'd200); exp_q.push_back(16'd150); exp_q.push_back(16'd100);
`endif
    snap();
    start_pulse();
    drive_window(1);
    wait_idle("threshold");
    checks++;
    if (obs_pot_q.size() - pb !== exp_q.size()) begin
      errors++; $display("FAIL threshold_pv_count got %0d want %0d", obs_pot_q.size() - pb, exp_q.size());
    end
    foreach (exp_q[i]) if (pb + i < obs_pot_q.size()) begin
      checks++;
      if (obs_pot_q[pb + i] !== exp_q[i]) begin
        errors++; $display("FAIL threshold_mp[%0d] got %0d want %0d", i, obs_pot_q[pb + i], $signed(exp_q[i]));
      end
    end
    checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL threshold_done_pulses got %0d want 1", done_cnt - db); end
  endtask

  task automatic test_saturation();
    int big;
    for (int s = 0; s < 2; s++) begin
      big = (s == 0) ? 28672 : -28672;
      threshold = 16'sd1000;
      win_cur.delete();
      win_last.delete();
      win_cur.push_back(big); win_last.push_back(1'b0);
      win_cur.push_back(big); win_last.push_back(1'b1);
      for (int t = 1; t < NT; t++) begin
        win_cur.push_back(big); win_last.push_back(1'b1);
      end
      model_window(1000);
      snap();
      start_pulse();
      drive_window(0);
      wait_idle("saturation");
      checks++;
      if (obs_pot_q.size() - pb !== exp_q.size()) begin
        errors++; $display("FAIL saturation_pv_count got %0d want %0d", obs_pot_q.size() - pb, exp_q.size());
      end
      if (pb < obs_pot_q.size()) begin
        checks++;
        if (obs_pot_q[pb] !== ((s == 0) ? 16'sd32767 : -16'sd32768)) begin
          errors++; $display("FAIL saturation_first got %0d want %0d", obs_pot_q[pb], (s == 0) ? 32767 : -32768);
        end
      end
      foreach (exp_q[i]) if (pb + i < obs_pot_q.size()) begin
        checks++;
        if (obs_pot_q[pb + i] !== exp_q[i]) begin
          errors++; $display("FAIL saturation_mp[%0d] got %0d want %0d", i, obs_pot_q[pb + i], $signed(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_gaps_busy_start();
    threshold = 16'sd1000;
    win_cur.delete();
    win_last.delete();
    win_cur.push_back(10); win_last.push_back(1'b0);
    win_cur.push_back(20); win_last.push_back(1'b0);
    win_cur.push_back(30); win_last.push_back(1'b1);
    for (int t = 1; t < NT; t++) begin
      win_cur.push_back(0); win_last.push_back(1'b1);
    end
    model_window(1000);
    snap();
    start_pulse();
    idle_cycles(2);
    send_beat(10, 1'b0);
    start_pulse();
    idle_cycles(1);
    send_beat(20, 1'b0);
    idle_cycles(3);
    send_beat(30, 1'b1);
    for (int t = 1; t < NT; t++) begin
      idle_cycles($urandom_range(0, 2));
      send_beat(0, 1'b1);
    end
    wait_idle("gaps");
    if (pb < obs_pot_q.size()) begin
      checks++;
      if (obs_pot_q[pb] !== 16'sd60) begin errors++; $display("FAIL gaps_first_mp got %0d want 60", obs_pot_q[pb]); end
    end
    checks++;
    if (obs_pot_q.size() - pb !== exp_q.size()) begin
      errors++; $display("FAIL gaps_pv_count got %0d want %0d", obs_pot_q.size() - pb, exp_q.size());
    end
    foreach (exp_q[i]) if (pb + i < obs_pot_q.size()) begin
      checks++;
      if (obs_pot_q[pb + i] !== exp_q[i]) begin
        errors++; $display("FAIL gaps_mp[%0d] got %0d want %0d", i, obs_pot_q[pb + i], $signed(exp_q[i]));
      end
    end
    checks++; if (rsp_cnt - rb != 1) begin errors++; $display("FAIL busy_start_rsp_pulses got %0d want 1", rsp_cnt - rb); end
    checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL busy_start_done_pulses got %0d want 1", done_cnt - db); end
  endtask

  task automatic test_random();
    int thr, lo, hi, nb;
    for (int w = 0; w < 8; w++) begin
      thr = int'($urandom_range(0, 3000)) - 500;
      if (w % 2 == 0) begin lo = -300; hi = 600; end
      else begin lo = -20000; hi = 20000; end
      threshold = 16'(thr);
      win_cur.delete();
      win_last.delete();
      for (int t = 0; t < NT; t++) begin
        nb = $urandom_range(1, 3);
        for (int b = 0; b < nb; b++) begin
          win_cur.push_back(int'($urandom_range(0, hi - lo)) + lo);
          win_last.push_back(b == nb - 1);
        end
      end
      model_window(thr);
      snap();
      start_pulse();
      drive_window(2);
      wait_idle("random");
      checks++;
      if (obs_pot_q.size() - pb !== exp_q.size()) begin
        errors++; $display("FAIL random_pv_count w%0d got %0d want %0d", w, obs_pot_q.size() - pb, exp_q.size());
      end
      foreach (exp_q[i]) if (pb + i < obs_pot_q.size()) begin
        checks++;
        if (obs_pot_q[pb + i] !== exp_q[i]) begin
          errors++; $display("FAIL random_mp w%0d[%0d] got %0d want %0d", w, i, obs_pot_q[pb + i], $signed(exp_q[i]));
        end
      end
      for (int i = 0; i < NT; i++) if (pb + i < pv_cyc_q.size() && lb + i < last_cyc_q.size()) begin
        checks++;
        if (pv_cyc_q[pb + i] - last_cyc_q[lb + i] != 2) begin
          errors++; $display("FAIL random_latency w%0d[%0d] got %0d want 2", w, i, pv_cyc_q[pb + i] - last_cyc_q[lb + i]);
        end
      end
      checks++; if (rsp_cnt - rb != 1) begin errors++; $display("FAIL random_rsp_pulses w%0d got %0d want 1", w, rsp_cnt - rb); end
    end
  endtask

  task automatic test_mid_reset();
    threshold = 16'sd1000;
    snap();
    start_pulse();
    send_beat(500, 1'b1);
    send_beat(200, 1'b0);
    @(negedge clk);
    checks++; if (membrane_potential !== 16'sd500) begin errors++; $display("FAIL midrst_pre_mp got %0d want 500", membrane_potential); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (membrane_potential !== 16'sd0) begin errors++; $display("FAIL midrst_mp got %0d want 0", membrane_potential); end
    checks++; if (timestep !== 2'd0) begin errors++; $display("FAIL midrst_timestep got %0d want 0", timestep); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b want 0", bus.in_ready); end
    checks++; if (potential_valid !== 1'b0 || done !== 1'b0 || reset_accumulated_spikes !== 1'b0) begin
      errors++; $display("FAIL midrst_pulses got pv=%b done=%b rsp=%b want 0 0 0", potential_valid, done, reset_accumulated_spikes);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    win_cur.delete();
    win_last.delete();
    for (int t = 0; t < NT; t++) begin
      win_cur.push_back(int'($urandom_range(0, 800)) - 200);
      win_last.push_back(1'b1);
    end
    model_window(1000);
    snap();
    start_pulse();
    @(negedge clk);
    checks++; if (reset_accumulated_spikes !== 1'b1) begin errors++; $display("FAIL midrst_rsp_high got %b want 1", reset_accumulated_spikes); end
    checks++; if (timestep !== 2'd0) begin errors++; $display("FAIL midrst_restart_ts got %0d want 0", timestep); end
    @(negedge clk);
    checks++; if (reset_accumulated_spikes !== 1'b0) begin errors++; $display("FAIL midrst_rsp_low got %b want 0", reset_accumulated_spikes); end
    drive_window(1);
    wait_idle("midrst");
    checks++;
    if (obs_pot_q.size() - pb !== exp_q.size()) begin
      errors++; $display("FAIL midrst_pv_count got %0d want %0d", obs_pot_q.size() - pb, exp_q.size());
    end
    foreach (exp_q[i]) if (pb + i < obs_pot_q.size()) begin
      checks++;
      if (obs_pot_q[pb + i] !== exp_q[i]) begin
        errors++; $display("FAIL midrst_mp[%0d] got %0d want %0d", i, obs_pot_q[pb + i], $signed(exp_q[i]));
      end
    end
    checks++; if (rsp_cnt - rb != 1) begin errors++; $display("FAIL midrst_rsp_pulses got %0d want 1", rsp_cnt - rb); end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    bus.in_valid   = 1'b0;
    bus.in_current = '0;
    bus.in_last    = 1'b0;
    test_reset();
    test_integrate();
    test_threshold();
    test_saturation();
    test_gaps_busy_start();
    test_random();
    test_mid_reset();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
